md_ctrl: RTL and testbench
==========================

// Module: md_ctrl
// PURPOSE
//   Sequences the HI/LO multiply-divide unit in the E stage. Latches operands on a
//   mult/multu/div/divu start, then holds busy for a fixed latency before committing
//   HI/LO. Handles mthi/mtlo as single-cycle writes. Produces the stall request that
//   freezes D/E while an HI/LO-using instruction meets a busy unit.
//   HI/LO values feed the M/W pipeline registers.
// PARAMETERS
//   MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//   DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//   clk         in   1   clock, all state updates on posedge
//   reset       in   1   synchronous, active-low reset
//   in_start    in   1   E-stage instr is mult/multu/div/divu/mthi/mtlo (one-cycle pulse)
//   in_op       in   3   0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; others = no-op
//   in_rs       in   32  operand A (dividend / mthi,mtlo source)
//   in_rt       in   32  operand B (divisor)
//   in_md_use   in   1   D-stage instr uses HI/LO (mult/div/mfhi/mflo/mthi/mtlo)
//   out_busy    out  1   unit running a mult/div
//   out_stall   out  1   stall request to hazard unit
//   out_hi      out  32  architectural HI
//   out_lo      out  32  architectural LO
// BEHAVIOUR
//   Reset (reset==0 at posedge): state IDLE, cnt=0, pending regs=0, out_hi=0,
//     out_lo=0, out_busy=0. Overrides every other input, including mid-operation:
//     an in-flight op is discarded and never commits.
//   FSM: IDLE, RUN. out_busy = (state==RUN). cnt is 4 bits wide, sized for DIV_CYCLES<=15.
//   IDLE, in_start with op 0-3 at edge k:
//     - Compute the result from in_rs/in_rt at that edge into pend_hi/pend_lo.
//     - Load cnt = MULT_CYCLES or DIV_CYCLES, then go to RUN.
//     - out_busy is 1 for exactly N cycles after edge k.
//   RUN: cnt decrements each edge. At the edge where cnt==1:
//     - out_hi<=pend_hi, out_lo<=pend_lo, state->IDLE.
//     - New HI/LO are visible in the first cycle busy is 0.
//   mthi/mtlo (op 4/5) in IDLE: out_hi (resp. out_lo) <= in_rs at that edge.
//     No busy, no latency.
//   in_start while RUN: ignored entirely, whatever the op. The hazard unit must prevent this.
//   Op codes 6/7: no effect.
//   Arithmetic:
//     - mult: signed 32x32 -> 64, {HI,LO}=product.
//     - multu: the unsigned equivalent.
//     - div: LO=quotient truncated toward zero, HI=remainder with the dividend's sign.
//     - divu: unsigned.
//     - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
//     - Divisor 0 (div/divu): the op still runs DIV_CYCLES busy cycles, then commits
//       nothing; HI/LO stay unchanged.
//   Stall (combinational): out_stall = in_md_use & (in_start | out_busy).
//     Covers the back-to-back start case the cycle before busy rises.
//   Nothing else is combinational: out_hi/out_lo come straight from registers.
// TESTING
//   1 reset=0 for 2 cycles mid-RUN, then reset=1: busy=0, hi=lo=0, and the old op
//     never commits.
//   2 mult rs=0xFFFFFFFF rt=2:
//     - busy high exactly 5 cycles.
//     - Then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
//     - multu with the same operands: hi=1, lo=0xFFFFFFFE.
//   3 div rs=-7 rt=2: after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     div 0x80000000 by -1: lo=0x80000000, hi=0.
//   4 Set hi=0x1234 via mthi. Then divu rs=5 rt=0:
//     - busy for 10 cycles.
//     - hi stays 0x1234, lo stays at its prior value.
//   5 md_use=1 with in_start=1, then with busy=1: stall=1 on each cycle.
//     - md_use=0 while busy: stall=0.
//     - md_use=1 in the first non-busy cycle: stall=0.
//   6 mtlo rs=0xA5A5A5A5 while RUN: ignored, lo unchanged, the pending op commits normally.

Source files
------------

// File: rtl/md_ctrl_if.sv
// E-stage multiply/divide bus: start/operands in, busy/stall/HI/LO out.
interface md_ctrl_if;
    logic        in_start;
    logic [2:0]  in_op;
    logic [31:0] in_rs;
    logic [31:0] in_rt;
    logic        in_md_use;
    logic        out_busy;
    logic        out_stall;
    logic [31:0] out_hi;
    logic [31:0] out_lo;

    modport master (
        output in_start, in_op, in_rs, in_rt, in_md_use,
        input  out_busy, out_stall, out_hi, out_lo
    );

    modport slave (
        input  in_start, in_op, in_rs, in_rt, in_md_use,
        output out_busy, out_stall, out_hi, out_lo
    );
endinterface

// File: rtl/md_ctrl.sv
// HI/LO multiply-divide sequencer: latches the result at start, holds busy for a
// fixed latency, then commits HI/LO. mthi/mtlo write immediately when idle.
module md_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic        clk,
    input logic        reset,
    md_ctrl_if.slave   bus
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [31:0] rs, rt;
    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, den_s, den_u;
    logic [31:0] q_mag, r_mag, quo_s, rem_s, quo_u, rem_u;

    assign rs = bus.in_rs;
    assign rt = bus.in_rt;

    // Result datapath; divisions run on magnitudes so the INT_MIN/-1 case wraps cleanly.
    always_comb begin
        prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
        prod_u = {32'd0, rs} * {32'd0, rt};
        abs_a  = rs[31] ? (~rs + 32'd1) : rs;
        abs_b  = rt[31] ? (~rt + 32'd1) : rt;
        // Zero divisor result is discarded; substitute 1 to keep the dividers defined.
        den_s  = (abs_b == 32'd0) ? 32'd1 : abs_b;
        den_u  = (rt == 32'd0) ? 32'd1 : rt;
        q_mag  = abs_a / den_s;
        r_mag  = abs_a % den_s;
        quo_s  = (rs[31] ^ rt[31]) ? (~q_mag + 32'd1) : q_mag;
        rem_s  = rs[31] ? (~r_mag + 32'd1) : r_mag;
        quo_u  = rs / den_u;
        rem_u  = rs % den_u;
    end

    // Next-state: start handling in idle, countdown and commit in run.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_hi_d    = pend_hi_q;
        pend_lo_d    = pend_lo_q;
        pend_valid_d = pend_valid_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_start) begin
                    case (bus.in_op)
                        3'd0: begin
                            {pend_hi_d, pend_lo_d} = prod_s;
                            pend_valid_d = 1'b1;
                            cnt_d        = 4'(MULT_CYCLES);
                            state_d      = StRun;
                        end
                        3'd1: begin
                            {pend_hi_d, pend_lo_d} = prod_u;
                            pend_valid_d = 1'b1;
                            cnt_d        = 4'(MULT_CYCLES);
                            state_d      = StRun;
                        end
                        3'd2: begin
                            pend_hi_d    = rem_s;
                            pend_lo_d    = quo_s;
                            pend_valid_d = (rt != 32'd0);
                            cnt_d        = 4'(DIV_CYCLES);
                            state_d      = StRun;
                        end
                        3'd3: begin
                            pend_hi_d    = rem_u;
                            pend_lo_d    = quo_u;
                            pend_valid_d = (rt != 32'd0);
                            cnt_d        = 4'(DIV_CYCLES);
                            state_d      = StRun;
                        end
                        3'd4:    hi_d = rs;
                        3'd5:    lo_d = rs;
                        default: ;
                    endcase
                end
            end
            StRun: begin
                if (cnt_q == 4'd1) begin
                    if (pend_valid_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    cnt_d   = 4'd0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous active-low reset that discards any in-flight op.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            pend_hi_q    <= 32'd0;
            pend_lo_q    <= 32'd0;
            pend_valid_q <= 1'b0;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_hi_q    <= pend_hi_d;
            pend_lo_q    <= pend_lo_d;
            pend_valid_q <= pend_valid_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
        end
    end

    // Outputs: registered HI/LO; stall also covers the start cycle before busy rises.
    always_comb begin
        bus.out_busy  = (state_q == StRun);
        bus.out_stall = bus.in_md_use & (bus.in_start | (state_q == StRun));
        bus.out_hi    = hi_q;
        bus.out_lo    = lo_q;
    end

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: vector table of ops plus hand sequences for reset,
// stall and start-while-running.
module tb_md_ctrl;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_bad;

    md_ctrl_if md_if ();

    md_ctrl #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (md_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        int          busy;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one start pulse and count the busy cycles that follow (bounded).
    task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          output int nbusy);
        md_if.in_start = 1'b1;
        md_if.in_op    = op;
        md_if.in_rs    = rs;
        md_if.in_rt    = rt;
        step();
        md_if.in_start = 1'b0;
        nbusy = 0;
        while (md_if.out_busy && nbusy < 40) begin
            nbusy++;
            step();
        end
    endtask

    initial begin
        int nb;
        n_vec = 0;
        n_bad = 0;

        //            op    rs            rt            busy hi            lo
        vecs[0]  = '{3'd4, 32'h0000_1234, 32'h0,        0,  32'h0000_1234, 32'h0000_0000};
        vecs[1]  = '{3'd0, 32'hFFFF_FFFF, 32'h2,        5,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[2]  = '{3'd1, 32'hFFFF_FFFF, 32'h2,        5,  32'h0000_0001, 32'hFFFF_FFFE};
        vecs[3]  = '{3'd2, 32'hFFFF_FFF9, 32'h2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000};
        vecs[5]  = '{3'd4, 32'h0000_1234, 32'h0,        0,  32'h0000_1234, 32'h8000_0000};
        vecs[6]  = '{3'd3, 32'h0000_0005, 32'h0,        10, 32'h0000_1234, 32'h8000_0000};
        vecs[7]  = '{3'd5, 32'hA5A5_A5A5, 32'h0,        0,  32'h0000_1234, 32'hA5A5_A5A5};
        vecs[8]  = '{3'd6, 32'hDEAD_BEEF, 32'h1,        0,  32'h0000_1234, 32'hA5A5_A5A5};
        vecs[9]  = '{3'd3, 32'd100,       32'd7,        10, 32'h0000_0002, 32'h0000_000E};
        vecs[10] = '{3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5, 32'h3FFF_FFFF, 32'h0000_0001};
        vecs[11] = '{3'd0, 32'hFFFF_FFFD, 32'h4,        5,  32'hFFFF_FFFF, 32'hFFFF_FFF4};
        vecs[12] = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD};

        reset           = 1'b0;
        md_if.in_start  = 1'b0;
        md_if.in_op     = 3'd0;
        md_if.in_rs     = 32'd0;
        md_if.in_rt     = 32'd0;
        md_if.in_md_use = 1'b0;
        step();
        step();
        chk("reset_busy", 32'(md_if.out_busy), 32'd0);
        chk("reset_hi", md_if.out_hi, 32'd0);
        chk("reset_lo", md_if.out_lo, 32'd0);
        reset = 1'b1;

        // Reset held for two cycles in the middle of a mult: op must never commit.
        md_if.in_start = 1'b1;
        md_if.in_op    = 3'd0;
        md_if.in_rs    = 32'd3;
        md_if.in_rt    = 32'd5;
        step();
        md_if.in_start = 1'b0;
        chk("midrun_busy", 32'(md_if.out_busy), 32'd1);
        step();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        chk("rst_mid_busy", 32'(md_if.out_busy), 32'd0);
        chk("rst_mid_hi", md_if.out_hi, 32'd0);
        chk("rst_mid_lo", md_if.out_lo, 32'd0);
        for (int i = 0; i < 8; i++) step();
        chk("rst_nocommit_hi", md_if.out_hi, 32'd0);
        chk("rst_nocommit_lo", md_if.out_lo, 32'd0);

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, nb);
            chk($sformatf("vec%0d_busy", i), 32'(nb), 32'(vecs[i].busy));
            chk($sformatf("vec%0d_hi", i), md_if.out_hi, vecs[i].hi);
            chk($sformatf("vec%0d_lo", i), md_if.out_lo, vecs[i].lo);
        end

        // Stall: start cycle, busy cycle, md_use low, then first idle cycle.
        md_if.in_md_use = 1'b1;
        md_if.in_start  = 1'b1;
        md_if.in_op     = 3'd0;
        md_if.in_rs     = 32'd2;
        md_if.in_rt     = 32'd3;
        #1;
        chk("stall_start", 32'(md_if.out_stall), 32'd1);
        step();
        md_if.in_start = 1'b0;
        #1;
        chk("stall_busy", 32'(md_if.out_stall), 32'd1);
        md_if.in_md_use = 1'b0;
        #1;
        chk("stall_nouse", 32'(md_if.out_stall), 32'd0);
        nb = 0;
        while (md_if.out_busy && nb < 40) begin
            nb++;
            step();
        end
        chk("stall_idle_busy", 32'(md_if.out_busy), 32'd0);
        md_if.in_md_use = 1'b1;
        #1;
        chk("stall_idle", 32'(md_if.out_stall), 32'd0);
        chk("stall_mul_hi", md_if.out_hi, 32'd0);
        chk("stall_mul_lo", md_if.out_lo, 32'd6);
        md_if.in_md_use = 1'b0;

        // mtlo arriving while a divu runs is ignored; the divu still commits.
        md_if.in_start = 1'b1;
        md_if.in_op    = 3'd3;
        md_if.in_rs    = 32'd100;
        md_if.in_rt    = 32'd7;
        step();
        md_if.in_start = 1'b0;
        nb = 0;
        while (md_if.out_busy && nb < 40) begin
            if (nb == 1) begin
                md_if.in_start = 1'b1;
                md_if.in_op    = 3'd5;
                md_if.in_rs    = 32'hA5A5_A5A5;
            end else begin
                md_if.in_start = 1'b0;
            end
            nb++;
            step();
            if (nb == 2) chk("mtlo_run_lo", md_if.out_lo, 32'd6);
        end
        md_if.in_start = 1'b0;
        chk("mtlo_run_busy", 32'(nb), 32'd10);
        chk("mtlo_run_hi", md_if.out_hi, 32'd2);
        chk("mtlo_run_lo_final", md_if.out_lo, 32'd14);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
